key_repeat_ctrl: RTL and testbench
==================================

Name: key_repeat_ctrl

Overview:
- Parametrised N-key input conditioner between the raw board pushbuttons and the game control FSM.
- Per key: synchronises, debounces and edge-detects the input.
- Per key: generates a one-cycle move pulse on press, then auto-repeat pulses after a delay (delayed auto shift), so left/right/down keys repeat while held.
- Per-key repeat enable; a global enable to freeze input during line clears and game-over.

Parameters:
- N_KEYS, 4, number of key channels.
- ACTIVE_LOW, 1, 1 = key_in is low when pressed (board KEY style); 0 = active-high.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (min 1).
- DAS_CYCLES, 5000000, cycles from initial press pulse to first repeat pulse (min 1).
- ARR_CYCLES, 1500000, cycles between successive repeat pulses (min 1).
- REPEAT_MASK, 4'b1110, bit k = 1 enables auto-repeat on key k; width N_KEYS.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- key_in  in  N_KEYS  raw asynchronous key levels.
- enable  in  1  1 = pulses allowed; 0 = all repeat FSMs forced idle.
- held  out  N_KEYS  debounced, active-high pressed level.
- press_pulse  out  N_KEYS  one cycle on each accepted press.
- release_pulse  out  N_KEYS  one cycle on each accepted release.
- move_pulse  out  N_KEYS  press pulse OR auto-repeat pulse; the game consumes only this.

Behaviour:
- Reset (resetn low, async): sync flops, stable state, counters cleared to "not pressed"; all outputs 0; FSMs IDLE. Release of reset is not itself a press, even if a key is held: the stable state starts at 0 and a held key is then accepted as a normal press after debounce.
- Polarity: the raw input is inverted when ACTIVE_LOW = 1, before synchronisation into a 2-flop synchroniser.
- Debounce, per key:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synced level equals the stable level; otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the stable level.
- Latency: the input first sampled pressed at edge 0 gives held = 1 and press_pulse = 1 after edge DEBOUNCE_CYCLES+3. Release has identical latency. held is registered.
- press_pulse / release_pulse: registered rising/falling edge of the stable level, exactly 1 cycle, independent of enable.
- Repeat FSM, per key, with a counter sized for max(DAS_CYCLES, ARR_CYCLES):
  - IDLE: on press edge with enable = 1, assert move_pulse. If REPEAT_MASK[k], go to DELAY with counter = 0; else stay IDLE.
  - DELAY: counter increments each cycle. At DAS_CYCLES-1, assert move_pulse, clear the counter and go to REPEAT.
  - REPEAT: counter increments. At ARR_CYCLES-1, assert move_pulse and clear the counter.
  - DELAY or REPEAT: stable level 0, or enable 0, goes to IDLE next edge with no pulse. A release takes priority over a coincident repeat pulse.
- First repeat: DAS_CYCLES cycles after the press pulse; subsequent repeats every ARR_CYCLES.
- enable = 0:
  - move_pulse is 0.
  - A key already held when enable rises produces no move_pulse until it is released and pressed again; no retroactive edge.
- Keys are fully independent. Simultaneous presses each pulse in the same cycle, and opposing keys are not arbitrated here.
- Mid-operation reset forces everything idle immediately; no pulses on reset deassertion.

Test Plan (DEBOUNCE_CYCLES=4, DAS_CYCLES=10, ARR_CYCLES=3, ACTIVE_LOW=1, N_KEYS=4, REPEAT_MASK=4'b1110):
- Reset held 5 cycles with key_in=4'b1111, then released, 50 idle cycles -> all outputs 0 throughout.
- key_in[1]=0 for 30 cycles starting at edge 0, then 1:
  - press_pulse[1] and move_pulse[1] at edge 7.
  - Repeat move_pulse[1] at edges 17, 20, 23, 26, 29, 32, 35.
  - held[1] falls and release_pulse[1] at edge 37.
  - Total of 8 move_pulse[1].
- key_in[0]=0 for 30 cycles (repeat masked) -> exactly 1 move_pulse[0] at edge 7, held[0] high edges 7-36.
- key_in[2] low for 3 cycles only (glitch < DEBOUNCE) -> held[2], press_pulse[2], move_pulse[2] never assert.
- key_in[1] held with enable dropped to 0 at edge 21 and raised at edge 25:
  - Pulses at 7 and 17 only.
  - No move_pulse for the rest of the hold.
  - release_pulse still fires.
- key_in[1] and key_in[3] pressed on the same edge, reset asserted at edge 19 -> both pulse at edges 7 and 17; all outputs 0 asynchronously at assertion; no pulse after deassertion until a new debounced press.

Source files
------------

// File: rtl/key_repeat_ctrl.sv
// N-key pushbutton conditioner: synchronise, debounce and edge-detect each key,
// then produce move pulses on press plus delayed auto-repeat while held.
//
// Repeat FSM states (one per key):
//   state    | meaning
//   S_IDLE   | waiting for an accepted press edge while enabled
//   S_DELAY  | press pulsed; counting the initial delay before the first repeat
//   S_REPEAT | repeating; counting the interval between successive repeats
module key_repeat_ctrl #(
  parameter int                N_KEYS          = 4,
  parameter bit                ACTIVE_LOW      = 1'b1,
  parameter int                DEBOUNCE_CYCLES = 250000,
  parameter int                DAS_CYCLES      = 5000000,
  parameter int                ARR_CYCLES      = 1500000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b1110
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              enable,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] move_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0] DAS_LAST = RP_W'(DAS_CYCLES - 1);
  localparam logic [RP_W-1:0] ARR_LAST = RP_W'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    localparam bit REP_EN = REPEAT_MASK[k];

    logic            raw_lvl;
    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            held_q, press_q, release_q;
    logic            rise;

    state_t          state_q, state_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    logic            move_q, move_d;

    assign raw_lvl = ACTIVE_LOW ? ~key_in[k] : key_in[k];

    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LIMIT) begin
        stable_d = ~stable_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // held_q lags stable_q by one cycle, so it doubles as the edge-detect history
    assign rise = stable_q & ~held_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= raw_lvl;
        sync2_q   <= sync1_q;
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        held_q    <= stable_q;
        press_q   <= rise;
        release_q <= ~stable_q & held_q;
      end
    end

    always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      move_d   = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise && enable) begin
            move_d = 1'b1;
            if (REP_EN) begin
              state_d  = S_DELAY;
              rp_cnt_d = '0;
            end
          end
        end
        S_DELAY: begin
          if (!stable_q || !enable) begin
            state_d  = S_IDLE;
            rp_cnt_d = '0;
          end else if (rp_cnt_q == DAS_LAST) begin
            move_d   = 1'b1;
            state_d  = S_REPEAT;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
        S_REPEAT: begin
          // release/disable is checked first so it wins over a coincident repeat
          if (!stable_q || !enable) begin
            state_d  = S_IDLE;
            rp_cnt_d = '0;
          end else if (rp_cnt_q == ARR_LAST) begin
            move_d   = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
        default: begin
          state_d  = S_IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        state_q  <= S_IDLE;
        rp_cnt_q <= '0;
        move_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        rp_cnt_q <= rp_cnt_d;
        move_q   <= move_d;
      end
    end

    assign held[k]          = held_q;
    assign press_pulse[k]   = press_q;
    assign release_pulse[k] = release_q;
    // a pulse already registered is suppressed as soon as enable drops
    assign move_pulse[k]    = move_q & enable;
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with small debounce/repeat timings.
// Edge e: inputs are applied 1 time unit after edge e-1; outputs are sampled on the falling edge after edge e.
module tb_key_repeat_ctrl;

  logic       CLOCK_50;
  logic       resetn;
  logic [3:0] key_in;
  logic       enable;
  logic [3:0] held, press_pulse, release_pulse, move_pulse;

  int checks   = 0;
  int failures = 0;
  int mcount;
  logic [3:0] eh, ep, er, em, pn;
  logic       en_n;

  key_repeat_ctrl #(
    .N_KEYS(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
    .DAS_CYCLES(10), .ARR_CYCLES(3), .REPEAT_MASK(4'b1110)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .key_in(key_in), .enable(enable),
    .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .move_pulse(move_pulse)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [3:0] xh, input logic [3:0] xp,
                     input logic [3:0] xr, input logic [3:0] xm);
    checks++;
    assert (held === xh) else begin
      failures++; $error("FAIL %s held got=%b exp=%b", tag, held, xh);
    end
    checks++;
    assert (press_pulse === xp) else begin
      failures++; $error("FAIL %s press_pulse got=%b exp=%b", tag, press_pulse, xp);
    end
    checks++;
    assert (release_pulse === xr) else begin
      failures++; $error("FAIL %s release_pulse got=%b exp=%b", tag, release_pulse, xr);
    end
    checks++;
    assert (move_pulse === xm) else begin
      failures++; $error("FAIL %s move_pulse got=%b exp=%b", tag, move_pulse, xm);
    end
  endtask

  // pressed keys p (active-high) applied for the next edge
  task automatic apply(input logic [3:0] p, input logic en);
    @(posedge CLOCK_50);
    #1;
    key_in = ~p;
    enable = en;
  endtask

  initial begin
    resetn = 1'b0;
    key_in = 4'b1111;
    enable = 1'b1;

    // reset held, then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("reset c=%0d", i), 4'b0, 4'b0, 4'b0, 4'b0);
    end
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("idle c=%0d", i), 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // key 1 held 30 cycles with auto-repeat
    mcount = 0;
    apply(4'b0010, 1'b1);
    for (int e = 0; e <= 45; e++) begin
      pn = (e + 1 <= 29) ? 4'b0010 : 4'b0000;
      apply(pn, 1'b1);
      @(negedge CLOCK_50);
      eh = (e >= 7 && e <= 36) ? 4'b0010 : 4'b0000;
      ep = (e == 7) ? 4'b0010 : 4'b0000;
      er = (e == 37) ? 4'b0010 : 4'b0000;
      em = (e inside {7, 17, 20, 23, 26, 29, 32, 35}) ? 4'b0010 : 4'b0000;
      mcount += int'(move_pulse[1]);
      chk($sformatf("key1 e=%0d", e), eh, ep, er, em);
    end
    checks++;
    assert (mcount === 8) else begin
      failures++; $error("FAIL key1_move_count got=%0d exp=8", mcount);
    end

    // key 0 held 30 cycles, repeat masked
    mcount = 0;
    apply(4'b0001, 1'b1);
    for (int e = 0; e <= 45; e++) begin
      pn = (e + 1 <= 29) ? 4'b0001 : 4'b0000;
      apply(pn, 1'b1);
      @(negedge CLOCK_50);
      eh = (e >= 7 && e <= 36) ? 4'b0001 : 4'b0000;
      ep = (e == 7) ? 4'b0001 : 4'b0000;
      er = (e == 37) ? 4'b0001 : 4'b0000;
      em = (e == 7) ? 4'b0001 : 4'b0000;
      mcount += int'(move_pulse[0]);
      chk($sformatf("key0 e=%0d", e), eh, ep, er, em);
    end
    checks++;
    assert (mcount === 1) else begin
      failures++; $error("FAIL key0_move_count got=%0d exp=1", mcount);
    end

    // key 2 glitch of 3 cycles: never accepted
    apply(4'b0100, 1'b1);
    for (int e = 0; e <= 20; e++) begin
      pn = (e + 1 <= 2) ? 4'b0100 : 4'b0000;
      apply(pn, 1'b1);
      @(negedge CLOCK_50);
      chk($sformatf("glitch2 e=%0d", e), 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // key 1 held, enable low for edges 21..24
    apply(4'b0010, 1'b1);
    for (int e = 0; e <= 45; e++) begin
      pn   = (e + 1 <= 29) ? 4'b0010 : 4'b0000;
      en_n = !((e + 1 >= 21) && (e + 1 <= 24));
      apply(pn, en_n);
      @(negedge CLOCK_50);
      eh = (e >= 7 && e <= 36) ? 4'b0010 : 4'b0000;
      ep = (e == 7) ? 4'b0010 : 4'b0000;
      er = (e == 37) ? 4'b0010 : 4'b0000;
      em = (e == 7 || e == 17) ? 4'b0010 : 4'b0000;
      chk($sformatf("enable e=%0d", e), eh, ep, er, em);
    end

    // keys 1 and 3 together, reset mid-hold at edge 19
    apply(4'b1010, 1'b1);
    for (int e = 0; e <= 18; e++) begin
      apply(4'b1010, 1'b1);
      @(negedge CLOCK_50);
      eh = (e >= 7) ? 4'b1010 : 4'b0000;
      ep = (e == 7) ? 4'b1010 : 4'b0000;
      em = (e == 7 || e == 17) ? 4'b1010 : 4'b0000;
      chk($sformatf("dual e=%0d", e), eh, ep, 4'b0000, em);
    end
    @(posedge CLOCK_50);
    #2 resetn = 1'b0;
    #1 chk("reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk($sformatf("reset_hold c=%0d", i), 4'b0, 4'b0, 4'b0, 4'b0);
    end
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      apply(4'b1010, 1'b1);
      @(negedge CLOCK_50);
      eh = (e >= 7) ? 4'b1010 : 4'b0000;
      ep = (e == 7) ? 4'b1010 : 4'b0000;
      em = (e == 7) ? 4'b1010 : 4'b0000;
      chk($sformatf("post_reset e=%0d", e), eh, ep, 4'b0000, em);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
